// File: rtl/mst_rx_chn_buf.sv
// Receive-side four-channel word buffer between the FT600 bus FSM and the
// sequence checker: per-channel FIFOs in one shared array, round-robin drain.
module mst_rx_chn_buf #(
    parameter int DW    = 32,
    parameter int BW    = 4,
    parameter int AW    = 4,
    parameter int AFULL = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [1:0]    wr_chn,
    input  logic [DW-1:0] wr_data,
    input  logic [BW-1:0] wr_be,
    output logic [3:0]    rx_afull,
    output logic [3:0]    rx_full,
    output logic [3:0]    rx_empty,
    output logic [3:0]    ovf_err,
    input  logic          rd_rdy,
    output logic          ch0_vld,
    output logic          ch1_vld,
    output logic          ch2_vld,
    output logic          ch3_vld,
    output logic [DW-1:0] chk_data,
    output logic [BW-1:0] chk_be
);

    localparam int DEPTH = 2**AW;
    localparam int EW    = DW + BW;

    logic [EW-1:0]          mem [4*DEPTH];
    logic [3:0][AW-1:0]     wr_ptr;
    logic [3:0][AW-1:0]     rd_ptr;
    logic [3:0][AW:0]       cnt;
    logic [3:0][AW:0]       cnt_nxt;
    logic [3:0]             inc;
    logic [3:0]             dec;
    logic [1:0]             last;
    logic [1:0]             win;
    logic [1:0]             idx;
    logic                   found;
    logic                   pop;
    logic                   push_ok;
    logic [3:0]             vld_q;

    assign push_ok = wr_vld && !flush && !rx_full[wr_chn];

    // A channel pushed from empty this cycle still has cnt==0, so it is
    // naturally excluded from the candidate set.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && cnt[idx] != '0) begin
                found = 1'b1;
                win   = idx;
            end
        end
        pop = rd_rdy && !flush && found;
    end

    always_comb begin
        inc     = '0;
        dec     = '0;
        cnt_nxt = cnt;
        for (int unsigned ch = 0; ch < 4; ch++) begin
            inc[ch] = push_ok && (wr_chn == 2'(ch));
            dec[ch] = pop && (win == 2'(ch));
            if (flush)
                cnt_nxt[ch] = '0;
            else if (inc[ch] && !dec[ch])
                cnt_nxt[ch] = cnt[ch] + (AW+1)'(1);
            else if (dec[ch] && !inc[ch])
                cnt_nxt[ch] = cnt[ch] - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_empty <= '1;
            rx_full  <= '0;
            rx_afull <= '0;
            ovf_err  <= '0;
            last     <= 2'd3;
            vld_q    <= '0;
            chk_data <= '0;
            chk_be   <= '0;
        end else begin
            cnt <= cnt_nxt;
            for (int unsigned ch = 0; ch < 4; ch++) begin
                rx_empty[ch] <= (cnt_nxt[ch] == '0);
                rx_full[ch]  <= (cnt_nxt[ch] == (AW+1)'(DEPTH));
                rx_afull[ch] <= (cnt_nxt[ch] >= (AW+1)'(AFULL));
                if (flush) begin
                    wr_ptr[ch] <= '0;
                    rd_ptr[ch] <= '0;
                end else begin
                    if (inc[ch]) wr_ptr[ch] <= wr_ptr[ch] + AW'(1);
                    if (dec[ch]) rd_ptr[ch] <= rd_ptr[ch] + AW'(1);
                end
            end
            if (flush)
                ovf_err <= '0;
            else if (wr_vld && rx_full[wr_chn])
                ovf_err[wr_chn] <= 1'b1;
            vld_q <= '0;
            if (pop) begin
                last        <= win;
                vld_q[win]  <= 1'b1;
                {chk_be, chk_data} <= mem[{win, rd_ptr[win]}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[{wr_chn, wr_ptr[wr_chn]}] <= {wr_be, wr_data};
    end

    assign ch0_vld = vld_q[0];
    assign ch1_vld = vld_q[1];
    assign ch2_vld = vld_q[2];
    assign ch3_vld = vld_q[3];

endmodule

// File: tb/tb_mst_rx_chn_buf.sv
// Directed self-checking bench for mst_rx_chn_buf.
module tb_mst_rx_chn_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wr_vld;
    logic [1:0]  wr_chn;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [3:0]  rx_afull, rx_full, rx_empty, ovf_err;
    logic        rd_rdy;
    logic        ch0_vld, ch1_vld, ch2_vld, ch3_vld;
    logic [31:0] chk_data;
    logic [3:0]  chk_be;
    logic [3:0]  vld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign vld = {ch3_vld, ch2_vld, ch1_vld, ch0_vld};

    mst_rx_chn_buf #(.DW(32), .BW(4), .AW(4), .AFULL(12)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_vld(wr_vld), .wr_chn(wr_chn), .wr_data(wr_data), .wr_be(wr_be),
        .rx_afull(rx_afull), .rx_full(rx_full), .rx_empty(rx_empty), .ovf_err(ovf_err),
        .rd_rdy(rd_rdy),
        .ch0_vld(ch0_vld), .ch1_vld(ch1_vld), .ch2_vld(ch2_vld), .ch3_vld(ch3_vld),
        .chk_data(chk_data), .chk_be(chk_be)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] d, input logic [3:0] be);
        wr_vld  = 1'b1;
        wr_chn  = ch;
        wr_data = d;
        wr_be   = be;
        tick();
        wr_vld  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rr_word(input int ch, input int k);
        return 32'hC000_0000 + 32'(ch * 256) + 32'(k);
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_vld = 1'b0; wr_chn = '0;
        wr_data = '0; wr_be = '0; rd_rdy = 1'b0;
        tick();
        check("rst_empty", rx_empty, 4'hF);
        check("rst_full", rx_full, 4'h0);
        check("rst_afull", rx_afull, 4'h0);
        check("rst_ovf", ovf_err, 4'h0);
        check("rst_vld", vld, 4'h0);
        check("rst_data", chk_data, 32'h0);
        check("rst_be", chk_be, 4'h0);
        rst_n = 1'b1;

        // reset mid-traffic
        for (int k = 0; k < 5; k++) push(2'd1, 32'h1100_0000 + 32'(k), 4'hF);
        check("mid_empty_before", rx_empty, 4'hD);
        rst_n = 1'b0;
        #1;
        check("mid_async_empty", rx_empty, 4'hF);
        check("mid_async_ovf", ovf_err, 4'h0);
        check("mid_async_vld", vld, 4'h0);
        tick();
        rst_n = 1'b1;
        push(2'd1, 32'h1111_0001, 4'h3);
        push(2'd0, 32'h0000_0001, 4'h1);
        rd_rdy = 1'b1;
        tick();
        check("mid_first_vld", vld, 4'b0001);
        check("mid_first_data", chk_data, 32'h0000_0001);
        check("mid_first_be", chk_be, 4'h1);
        tick();
        check("mid_second_vld", vld, 4'b0010);
        check("mid_second_data", chk_data, 32'h1111_0001);
        tick();
        check("mid_idle_vld", vld, 4'h0);
        check("mid_idle_empty", rx_empty, 4'hF);

        // single word latency
        push(2'd2, 32'hA5A5_0001, 4'hF);
        check("lat_n1_vld", vld, 4'h0);
        tick();
        check("lat_n2_vld", vld, 4'b0100);
        check("lat_n2_data", chk_data, 32'hA5A5_0001);
        check("lat_n2_be", chk_be, 4'hF);
        tick();
        check("lat_after_vld", vld, 4'h0);
        check("lat_hold_data", chk_data, 32'hA5A5_0001);

        // round-robin
        pulse_reset();
        rd_rdy = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int ch = 0; ch < 4; ch++)
                push(2'(ch), rr_word(ch, k), 4'(ch + k + 1));
        check("rr_loaded_empty", rx_empty, 4'h0);
        rd_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rr_vld", vld, 64'(4'b0001 << (i % 4)));
            check("rr_data", chk_data, rr_word(i % 4, i / 4));
            check("rr_be", chk_be, 64'(4'((i % 4) + (i / 4) + 1)));
        end
        check("rr_done_empty", rx_empty, 4'hF);
        tick();
        check("rr_done_vld", vld, 4'h0);

        // full / overflow on ch3
        rd_rdy = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            push(2'd3, 32'hD300_0000 + 32'(k), 4'hA);
            check("ovf_afull3", rx_afull[3], (k >= 12));
            check("ovf_full3", rx_full[3], (k >= 16));
            check("ovf_err3", ovf_err[3], (k >= 17));
            check("ovf_empty3", rx_empty[3], 1'b0);
        end
        rd_rdy = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("ovf_drain_vld", vld, 4'b1000);
            check("ovf_drain_data", chk_data, 32'hD300_0000 + 32'(k));
        end
        tick();
        check("ovf_end_vld", vld, 4'h0);
        check("ovf_end_empty", rx_empty, 4'hF);
        check("ovf_end_full", rx_full, 4'h0);
        check("ovf_end_afull", rx_afull, 4'h0);
        check("ovf_sticky", ovf_err, 4'b1000);

        // simultaneous push/pop across pointer wrap on ch1
        rd_rdy = 1'b0;
        for (int k = 0; k < 8; k++) push(2'd1, 32'hB100_0000 + 32'(k), 4'h5);
        rd_rdy = 1'b1;
        wr_vld = 1'b1;
        wr_chn = 2'd1;
        wr_be  = 4'h5;
        for (int i = 0; i < 40; i++) begin
            wr_data = 32'hB100_0000 + 32'(i + 8);
            tick();
            check("wrap_vld", vld, 4'b0010);
            check("wrap_data", chk_data, 32'hB100_0000 + 32'(i));
            check("wrap_empty1", rx_empty[1], 1'b0);
            check("wrap_afull", rx_afull, 4'h0);
            check("wrap_full", rx_full, 4'h0);
        end
        wr_vld = 1'b0;
        for (int i = 40; i < 48; i++) begin
            tick();
            check("wrap_tail_vld", vld, 4'b0010);
            check("wrap_tail_data", chk_data, 32'hB100_0000 + 32'(i));
        end
        tick();
        check("wrap_end_vld", vld, 4'h0);
        check("wrap_end_empty", rx_empty, 4'hF);

        // flush
        rd_rdy = 1'b0;
        for (int k = 0; k < 3; k++) push(2'd0, 32'hF000_0000 + 32'(k), 4'h1);
        for (int k = 0; k < 17; k++) push(2'd2, 32'hF200_0000 + 32'(k), 4'h2);
        check("fl_pre_ovf", ovf_err, 4'b1100);
        check("fl_pre_empty", rx_empty, 4'b1010);
        check("fl_pre_full", rx_full, 4'b0100);
        flush   = 1'b1;
        rd_rdy  = 1'b1;
        wr_vld  = 1'b1;
        wr_chn  = 2'd0;
        wr_data = 32'hFFFF_FFFF;
        wr_be   = 4'hF;
        tick();
        flush  = 1'b0;
        wr_vld = 1'b0;
        check("fl_empty", rx_empty, 4'hF);
        check("fl_ovf", ovf_err, 4'h0);
        check("fl_full", rx_full, 4'h0);
        check("fl_afull", rx_afull, 4'h0);
        check("fl_vld", vld, 4'h0);
        tick();
        check("fl_nostore_vld", vld, 4'h0);
        check("fl_nostore_empty", rx_empty, 4'hF);
        push(2'd2, 32'h2222_0001, 4'h7);
        tick();
        check("fl_post_vld", vld, 4'b0100);
        check("fl_post_data", chk_data, 32'h2222_0001);
        check("fl_post_be", chk_be, 4'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
